// File: rtl/wb_rr_arbiter_pkg.sv
// wb_arb_pkg: shared state encoding and sizing helpers for the round-robin Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANTED = 1'b1} arb_state_e;
  function automatic int sel_width(input int data_width, input int granularity);
    return data_width / granularity;
  endfunction
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: bundled master-side and slave-side Wishbone signals of the arbiter
interface wb_rr_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int GRANULARITY = 8
);
  localparam int SW = sel_width(DATA_WIDTH, GRANULARITY);
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*SW-1:0]         m_sel_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic [NUM_MASTERS-1:0]            m_rty_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [SW-1:0]                     s_sel_o;
  logic                              s_we_o;
  logic                              s_stb_o;
  logic                              s_cyc_o;
  logic [DATA_WIDTH-1:0]             s_dat_i;
  logic                              s_ack_i;
  logic                              s_err_i;
  logic                              s_rty_i;
  // slave: the arbiter's view (slave to the masters, driver of the shared bus)
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
  // master: the environment's view (requesting masters plus the shared slave)
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// rr_pick: rotating-priority picker, first request found after index last_i wins
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o
);
  logic [IW-1:0] idx;
  logic          found;
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last_i) + i) % N);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_idx_o     = idx;
      end
    end
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: cyc-locked round-robin Wishbone B4 arbiter for one shared slave.
// Optional watchdog error on a stalled slave when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int GRANULARITY    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_rr_arbiter_if.slave         bus,
  output logic [NUM_MASTERS-1:0] grant_o
);
  localparam int SW = sel_width(DATA_WIDTH, GRANULARITY);
  localparam int IW = idx_width(NUM_MASTERS);
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("wb_rr_arbiter: unsupported parameter set");
  end
  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [IW-1:0]          win_idx;
  logic                   granted, stb_raw, resp, to_fire;
  logic [ADDR_WIDTH-1:0]  adr_a [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  dat_a [NUM_MASTERS];
  logic [SW-1:0]          sel_a [NUM_MASTERS];
  genvar k;
  for (k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign adr_a[k] = bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_a[k] = bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign sel_a[k] = bus.m_sel_i[k*SW +: SW];
  end
  rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req_i     (bus.m_cyc_i),
    .last_i    (last_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );
  assign granted = state_q == ARB_GRANTED;
  assign stb_raw = granted && bus.m_stb_i[gidx_q];
  assign resp    = bus.s_ack_i || bus.s_err_i || bus.s_rty_i;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    if (!granted && |bus.m_cyc_i) begin
      state_d = ARB_GRANTED;
      grant_d = win_oh;
      gidx_d  = win_idx;
    end else if (granted && !bus.m_cyc_i[gidx_q]) begin
      state_d = ARB_IDLE;
      grant_d = '0;
      last_d  = gidx_q;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= !rst ? ARB_IDLE : state_d;
    grant_q <= !rst ? '0 : grant_d;
    last_q  <= !rst ? IW'(NUM_MASTERS - 1) : last_d;
    gidx_q  <= !rst ? '0 : gidx_d;
  end
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  // counts stalled strobe cycles; the watchdog answers for the slave but keeps the grant
  assign to_fire = stb_raw && !resp && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d   = (!granted || resp || to_fire) ? '0 : stb_raw ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) begin
    cnt_q <= !rst ? '0 : cnt_d;
  end
`else
  assign to_fire = 1'b0;
`endif
  assign grant_o     = grant_q;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = grant_q & {NUM_MASTERS{bus.s_ack_i}};
  assign bus.m_err_o = grant_q & {NUM_MASTERS{bus.s_err_i || to_fire}};
  assign bus.m_rty_o = grant_q & {NUM_MASTERS{bus.s_rty_i}};
  assign bus.s_adr_o = granted ? adr_a[gidx_q] : '0;
  assign bus.s_dat_o = granted ? dat_a[gidx_q] : '0;
  assign bus.s_sel_o = granted ? sel_a[gidx_q] : '0;
  assign bus.s_we_o  = granted && bus.m_we_i[gidx_q];
  assign bus.s_stb_o = stb_raw && !to_fire;
  assign bus.s_cyc_o = granted && bus.m_cyc_i[gidx_q];
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed checks of the round-robin arbiter (watchdog part follows WB_ARB_TIMEOUT_EN)
module tb_wb_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant;
  int         n_checks = 0;
  int         n_errors = 0;
  wb_rr_arbiter_if #(.NUM_MASTERS(2), .DATA_WIDTH(128), .ADDR_WIDTH(32), .GRANULARITY(8)) bus ();
  wb_rr_arbiter #(
    .NUM_MASTERS(2), .DATA_WIDTH(128), .ADDR_WIDTH(32), .GRANULARITY(8), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .grant_o (grant)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  initial begin
    logic [1:0]   exp;
    logic [127:0] wdat;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
    bus.m_stb_i = 2'b11; bus.m_cyc_i = 2'b11;
    bus.s_dat_i = '0; bus.s_ack_i = 1'b1; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    // reset held with both masters requesting and a spurious slave ack
    repeat (3) begin
      cyc();
      check("rst_grant", grant, 2'b00);
      check("rst_s_cyc", bus.s_cyc_o, 1'b0);
      check("rst_ack", bus.m_ack_o, 2'b00);
    end
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; bus.s_ack_i = 1'b0; rst = 1'b1;
    // M0 single read
    bus.m_adr_i[0 +: 32] = 32'h10; bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
    #1 check("rd_latency_s_cyc", bus.s_cyc_o, 1'b0);
    cyc();
    check("rd_grant", grant, 2'b01);
    check("rd_s_cyc", bus.s_cyc_o, 1'b1);
    check("rd_s_stb", bus.s_stb_o, 1'b1);
    check("rd_s_adr", bus.s_adr_o, 32'h10);
    check("rd_s_we", bus.s_we_o, 1'b0);
    cyc();
    check("rd_wait_ack", bus.m_ack_o, 2'b00);
    cyc();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    #1 check("rd_ack", bus.m_ack_o, 2'b01);
    check("rd_dat", bus.m_dat_o, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    cyc();
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    #1 check("rd_drop_s_cyc", bus.s_cyc_o, 1'b0);
    cyc();
    check("rd_idle_grant", grant, 2'b00);
    // fair alternation from a fresh reset
    rst = 1'b0;
    cyc();
    rst = 1'b1; bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp = (g % 2 == 0) ? 2'b01 : 2'b10;
      cyc();
      check($sformatf("rr_grant%0d", g), grant, exp);
      bus.s_ack_i = 1'b1;
      #1 check($sformatf("rr_ack%0d", g), bus.m_ack_o, exp);
      cyc();
      bus.s_ack_i = 1'b0; bus.m_cyc_i = bus.m_cyc_i & ~exp; bus.m_stb_i = bus.m_stb_i & ~exp;
      cyc();
      check($sformatf("rr_idle%0d", g), grant, 2'b00);
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    end
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    // M1 holds cyc over four writes while M0 waits
    bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10; bus.m_we_i = 2'b10;
    bus.m_sel_i[16 +: 16] = 16'hFFFF;
    cyc();
    check("wr_grant_m1", grant, 2'b10);
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wdat = {4{32'(i + 32'hA0)}};
      bus.m_adr_i[32 +: 32] = 32'(32'h100 + i * 16);
      bus.m_dat_i[128 +: 128] = wdat;
      bus.s_ack_i = 1'b1;
      #1 check($sformatf("wr_adr%0d", i), bus.s_adr_o, 32'(32'h100 + i * 16));
      check($sformatf("wr_dat%0d", i), bus.s_dat_o, wdat);
      check($sformatf("wr_we%0d", i), bus.s_we_o, 1'b1);
      check($sformatf("wr_sel%0d", i), bus.s_sel_o, 16'hFFFF);
      check($sformatf("wr_ack%0d", i), bus.m_ack_o, 2'b10);
      cyc();
      check($sformatf("wr_hold%0d", i), grant, 2'b10);
    end
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_we_i = 2'b00;
    cyc();
    check("wr_idle", grant, 2'b00);
    cyc();
    check("wr_then_m0", grant, 2'b01);
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    cyc();
    // reset in the middle of an M0 transfer
    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
    cyc();
    check("ab_grant", grant, 2'b01);
    check("ab_s_cyc", bus.s_cyc_o, 1'b1);
    rst = 1'b0;
    cyc();
    check("ab_s_cyc_off", bus.s_cyc_o, 1'b0);
    check("ab_s_stb_off", bus.s_stb_o, 1'b0);
    check("ab_grant_off", grant, 2'b00);
    rst = 1'b1; bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11; bus.s_ack_i = 1'b1;
    #1 check("ab_late_ack", bus.m_ack_o, 2'b00);
    bus.s_ack_i = 1'b0;
    cyc();
    check("ab_m0_first", grant, 2'b01);
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    cyc();
    // hung slave
    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check($sformatf("to_err%0d", k), bus.m_err_o, (k == 8) ? 2'b01 : 2'b00);
      check($sformatf("to_stb%0d", k), bus.s_stb_o, (k == 8) ? 1'b0 : 1'b1);
      check($sformatf("to_grant%0d", k), grant, 2'b01);
    end
`else
    for (int k = 1; k <= 100; k++) begin
      cyc();
      check($sformatf("hang_err%0d", k), bus.m_err_o, 2'b00);
      check($sformatf("hang_stb%0d", k), bus.s_stb_o, 1'b1);
    end
    check("hang_grant", grant, 2'b01);
`endif
    bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    cyc();
    check("end_idle", grant, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
